// File: rtl/conv_viterbi_codec_pkg.sv
// Shared constants and trellis helpers for the K=3, rate 1/2 (7,5) codec.
package conv_viterbi_codec_pkg;

  localparam int unsigned K       = 3;
  localparam int unsigned NSTATES = 4;
  localparam logic [K-1:0] G0     = 3'b111;  // octal 7
  localparam logic [K-1:0] G1     = 3'b101;  // octal 5

  typedef enum logic [1:0] {StIdle, StRun, StDrain} dec_state_e;

  // Encoder output {g0,g1} for state {s1,s0} and input bit.
  function automatic logic [1:0] exp_sym(logic [1:0] st, logic in_bit);
    logic [K-1:0] r;
    r = {in_bit, st};
    return {^(r & G0), ^(r & G1)};
  endfunction

  // Hamming distance between two 2-bit symbols.
  function automatic logic [1:0] hamming(logic [1:0] a, logic [1:0] b);
    return {1'b0, a[1] ^ b[1]} + {1'b0, a[0] ^ b[0]};
  endfunction

  // Predecessor of next state {b,s1} whose oldest bit was y.
  function automatic logic [1:0] pred_state(logic [1:0] ns, logic y);
    return {ns[0], y};
  endfunction

endpackage

// File: rtl/conv_viterbi_codec_convolution.sv
// Rate 1/2, K=3 convolutional encoder with registered output.
module conv_viterbi_codec_convolution
  import conv_viterbi_codec_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic       data_i,
  output logic       valid_o,
  output logic [1:0] data_o
);

  logic [1:0] state_q;

  // Shift register and output symbol; everything holds while valid_i is low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= 2'b00;
      valid_o <= 1'b0;
      data_o  <= 2'b00;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        data_o  <= exp_sym(state_q, data_i);
        state_q <= {data_i, state_q[1]};
      end
    end
  end

endmodule

// File: rtl/conv_viterbi_codec_viterbi.sv
// 4-state hard-decision Viterbi decoder, register-exchange survivors.
module conv_viterbi_codec_viterbi
  import conv_viterbi_codec_pkg::*;
#(
  parameter int unsigned TbDepth = 16,
  parameter int unsigned PmW     = 6
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       valid_i,
  input  logic [1:0] data_i,
  output logic       valid_o,
  output logic       data_o
);

  localparam int unsigned CntW    = $clog2(TbDepth + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(TbDepth);
  localparam logic [PmW-1:0]  PmInit  = PmW'(8);

  typedef logic [PmW-1:0]     pm_t;
  typedef logic [TbDepth-1:0] surv_t;

  dec_state_e      state_q, state_d;
  pm_t             pm_q [NSTATES];
  pm_t             pm_d [NSTATES];
  surv_t           surv_q [NSTATES];
  surv_t           surv_d [NSTATES];
  logic [CntW-1:0] cnt_q, cnt_d;
  surv_t           drain_q, drain_d;
  logic            valid_o_d, data_o_d;

  pm_t        pm_old [NSTATES];
  surv_t      surv_old [NSTATES];
  pm_t        pm_sum [NSTATES];
  surv_t      surv_new [NSTATES];
  logic       top_bit [NSTATES];
  pm_t        pm_min, pm_cur_min, m0, m1;
  logic [1:0] ns_v, p0, p1, pred, best_new, best_cur;
  surv_t      aligned;

  // Add-compare-select; a frame start feeds the initial metrics straight in.
  always_comb begin
    ns_v = 2'b00; p0 = 2'b00; p1 = 2'b00; pred = 2'b00; m0 = '0; m1 = '0;
    for (int s = 0; s < NSTATES; s++) begin
      pm_old[s]   = (state_q == StIdle) ? ((s == 0) ? '0 : PmInit) : pm_q[s];
      surv_old[s] = (state_q == StIdle) ? '0 : surv_q[s];
    end
    for (int s = 0; s < NSTATES; s++) begin
      ns_v = 2'(s);
      p0   = pred_state(ns_v, 1'b0);
      p1   = pred_state(ns_v, 1'b1);
      m0   = pm_old[p0] + PmW'(hamming(data_i, exp_sym(p0, ns_v[1])));
      m1   = pm_old[p1] + PmW'(hamming(data_i, exp_sym(p1, ns_v[1])));
      // Strict compare so the lower-numbered predecessor wins ties.
      pred        = (m1 < m0) ? p1 : p0;
      pm_sum[s]   = (m1 < m0) ? m1 : m0;
      surv_new[s] = {surv_old[pred][TbDepth-2:0], ns_v[1]};
      top_bit[s]  = surv_old[pred][TbDepth-1];
    end
    pm_min   = pm_sum[0];
    best_new = 2'b00;
    pm_cur_min = pm_q[0];
    best_cur   = 2'b00;
    for (int s = 1; s < NSTATES; s++) begin
      if (pm_sum[s] < pm_min) begin
        pm_min   = pm_sum[s];
        best_new = 2'(s);
      end
      if (pm_q[s] < pm_cur_min) begin
        pm_cur_min = pm_q[s];
        best_cur   = 2'(s);
      end
    end
    // Oldest still-undecided bit of the best path moved to the MSB.
    aligned = surv_q[best_cur] << (CntFull - cnt_q);
  end

  // Frame control: accept symbols, emit steady decisions, then drain.
  always_comb begin
    state_d   = state_q;
    pm_d      = pm_q;
    surv_d    = surv_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    valid_o_d = 1'b0;
    data_o_d  = data_o;
    unique case (state_q)
      StIdle, StRun: begin
        if (valid_i) begin
          for (int s = 0; s < NSTATES; s++) begin
            pm_d[s]   = pm_sum[s] - pm_min;
            surv_d[s] = surv_new[s];
          end
          if (cnt_q == CntFull) begin
            valid_o_d = 1'b1;
            data_o_d  = top_bit[best_new];
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          state_d = StRun;
        end else if (state_q == StRun) begin
          // First drained bit goes out in the frame-end cycle itself.
          valid_o_d = 1'b1;
          data_o_d  = aligned[TbDepth-1];
          drain_d   = aligned << 1;
          cnt_d     = cnt_q - 1'b1;
          state_d   = (cnt_q == CntW'(1)) ? StIdle : StDrain;
        end
      end
      StDrain: begin
        valid_o_d = 1'b1;
        data_o_d  = drain_q[TbDepth-1];
        drain_d   = drain_q << 1;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == CntW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      drain_q <= '0;
      valid_o <= 1'b0;
      data_o  <= 1'b0;
      for (int s = 0; s < NSTATES; s++) begin
        pm_q[s]   <= '0;
        surv_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
      valid_o <= valid_o_d;
      data_o  <= data_o_d;
      pm_q    <= pm_d;
      surv_q  <= surv_d;
    end
  end

endmodule

// File: rtl/conv_viterbi_codec.sv
// Codec top: encoder and decoder side by side, wired to the pins.
module conv_viterbi_codec
  import conv_viterbi_codec_pkg::*;
#(
  parameter int unsigned TB_DEPTH = 16,
  parameter int unsigned PM_W     = 6
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       valid_i,
  input  logic       data_i,
  output logic       valid_e,
  output logic [1:0] data_e,
  input  logic       valid_d,
  input  logic [1:0] data_r,
  output logic       valid_o,
  output logic       data_o
);

  conv_viterbi_codec_convolution u_convolution (
    .clk_i   (CLK),
    .rst_i   (RST),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_o (valid_e),
    .data_o  (data_e)
  );

  conv_viterbi_codec_viterbi #(
    .TbDepth (TB_DEPTH),
    .PmW     (PM_W)
  ) u_viterbi (
    .clk_i   (CLK),
    .rst_i   (RST),
    .valid_i (valid_d),
    .data_i  (data_r),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

endmodule

// File: tb/tb_conv_viterbi_codec.sv
// Bench: encoder vector table, then loopback frames checked by a scoreboard.
module tb_conv_viterbi_codec;

  localparam int TB_DEPTH = 16;

  logic       CLK = 1'b0;
  logic       RST, valid_i, data_i, valid_e, valid_d, valid_o, data_o;
  logic [1:0] data_e, data_r;

  int total = 0;
  int bad   = 0;
  bit exp_q[$];
  bit exp_bit;
  int ecnt;
  int err_idx = -1;
  bit loop_en = 1'b0;

  typedef struct {
    logic       vi;
    logic       di;
    logic       ve;
    logic [1:0] de;
  } enc_vec_t;

  enc_vec_t vecs [8];

  always #5 CLK = ~CLK;

  // Symbol counter for error injection on the loopback path.
  always @(posedge CLK) begin
    if (RST) ecnt <= 0;
    else if (valid_e) ecnt <= ecnt + 1;
  end

  assign valid_d = valid_e & loop_en;
  assign data_r  = data_e ^ ((valid_e && ecnt == err_idx) ? 2'b10 : 2'b00);

  conv_viterbi_codec #(
    .TB_DEPTH (TB_DEPTH),
    .PM_W     (6)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .valid_i (valid_i),
    .data_i  (data_i),
    .valid_e (valid_e),
    .data_e  (data_e),
    .valid_d (valid_d),
    .data_r  (data_r),
    .valid_o (valid_o),
    .data_o  (data_o)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every decoded bit must match the oldest expected bit.
  always @(negedge CLK) begin
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid_o: got data_o=%0b expected no output", data_o);
      end else begin
        exp_bit = exp_q.pop_front();
        check("decoded_bit", int'(data_o), int'(exp_bit));
      end
    end
  end

  task automatic do_reset();
    RST     = 1'b1;
    valid_i = 1'b0;
    data_i  = 1'b0;
    err_idx = -1;
    exp_q.delete();
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
    RST = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input bit expect_out);
    valid_i = 1'b1;
    data_i  = b;
    if (expect_out) exp_q.push_back(b);
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    valid_i = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Frame end on the decoder is one edge after the last encoder input.
  task automatic wait_drain(input string name);
    valid_i = 1'b0;
    for (int i = 1; i <= TB_DEPTH + 3 && exp_q.size() != 0; i++) begin
      @(posedge CLK);
      #2;
    end
    check(name, exp_q.size(), 0);
    idle_cycles(4);
  endtask

  task automatic run_pattern64(input int err);
    do_reset();
    loop_en = 1'b1;
    err_idx = err;
    for (int i = 0; i < 64; i++) drive_bit(logic'(i % 3 == 1), 1'b1);
    wait_drain((err < 0) ? "frame64_drained" : "frame64_err_drained");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [4:0]  short_bits;
    logic [7:0]  byte_bits;
    logic [29:0] f2_bits;

    vecs[0] = '{vi: 1'b1, di: 1'b1, ve: 1'b1, de: 2'b11};
    vecs[1] = '{vi: 1'b1, di: 1'b0, ve: 1'b1, de: 2'b10};
    vecs[2] = '{vi: 1'b1, di: 1'b0, ve: 1'b1, de: 2'b11};
    vecs[3] = '{vi: 1'b0, di: 1'b1, ve: 1'b0, de: 2'b11};
    vecs[4] = '{vi: 1'b1, di: 1'b1, ve: 1'b1, de: 2'b11};
    vecs[5] = '{vi: 1'b1, di: 1'b1, ve: 1'b1, de: 2'b01};
    vecs[6] = '{vi: 1'b1, di: 1'b1, ve: 1'b1, de: 2'b10};
    vecs[7] = '{vi: 1'b0, di: 1'b0, ve: 1'b0, de: 2'b10};

    RST     = 1'b1;
    valid_i = 1'b0;
    data_i  = 1'b0;
    loop_en = 1'b0;
    do_reset();
    check("reset_valid_e", int'(valid_e), 0);
    check("reset_data_e", int'(data_e), 0);
    check("reset_valid_o", int'(valid_o), 0);
    check("reset_data_o", int'(data_o), 0);

    // Encoder only; decoder input gated off.
    for (int i = 0; i < 8; i++) begin
      valid_i = vecs[i].vi;
      data_i  = vecs[i].di;
      @(posedge CLK);
      #1;
      check($sformatf("enc_valid_e[%0d]", i), int'(valid_e), int'(vecs[i].ve));
      check($sformatf("enc_data_e[%0d]", i), int'(data_e), int'(vecs[i].de));
    end

    run_pattern64(-1);
    run_pattern64(20);

    // Frame shorter than the traceback depth.
    do_reset();
    loop_en    = 1'b1;
    short_bits = 5'b11010;
    for (int i = 4; i >= 0; i--) drive_bit(short_bits[i], 1'b1);
    wait_drain("short_frame_drained");

    // Reset mid-frame: no output may follow.
    do_reset();
    loop_en = 1'b1;
    for (int i = 0; i < 10; i++) drive_bit(logic'(i % 2), 1'b0);
    do_reset();
    loop_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK);
      #1;
      check("abort_valid_o", int'(valid_o), 0);
    end
    byte_bits = 8'b10110010;
    for (int i = 7; i >= 0; i--) drive_bit(byte_bits[i], 1'b1);
    wait_drain("after_abort_drained");

    // Back-to-back frames: the first 7 symbols of frame 2 land in the drain.
    do_reset();
    loop_en   = 1'b1;
    byte_bits = 8'b11010011;
    for (int i = 7; i >= 0; i--) drive_bit(byte_bits[i], 1'b1);
    idle_cycles(1);
    f2_bits = 30'b10111_00_01101001110101100111011;
    for (int i = 0; i < 30; i++) drive_bit(f2_bits[29-i], i >= 7);
    wait_drain("back_to_back_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
